// File: rtl/spi_encoder_hub_pkg.sv
// Shared types and constants for the SPI encoder hub: FSM states, command
// opcodes and the identification byte returned during the command phase.
package spi_enc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    DATA  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_READ       = 2'b00,
    OP_READ_CLEAR = 2'b01
  } opcode_t;

  localparam logic [7:0] INVALID_BYTE = 8'hFF;

  // High nibble: channel count minus one; low nibble: bytes per channel minus one.
  function automatic logic [7:0] idByte(input int numCh, input int countW);
    return {4'(numCh - 1), 4'(countW / 8 - 1)};
  endfunction

endpackage

// File: rtl/spi_encoder_hub_sync_edge.sv
// Multi-flop synchroniser with a glitch filter and registered edge strobes.
// The level only moves once every synchroniser stage agrees on the new value.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;

  // During reset the level tracks the pin directly, so no edge is reported on release.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[SYNC_STAGES-2:0], in};
    if (reset) begin
      r_level <= r_sync[SYNC_STAGES-1];
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if ((&r_sync) && !r_level) begin
        r_level <= 1'b1;
        r_rise  <= 1'b1;
      end else if (!(|r_sync) && r_level) begin
        r_level <= 1'b0;
        r_fall  <= 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule

// File: rtl/spi_encoder_hub.sv
// SPI mode-0 slave that snapshots N encoder counters at chip-select and
// streams them MSB-first with channel auto-increment and optional read-and-clear.
module spi_encoder_hub
  import spi_enc_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH*COUNT_W-1:0] encCounts,
  input  logic                      cs,
  input  logic                      sck,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      misoEn,
  output logic [NUM_CH-1:0]         clearReq,
  output logic                      busy,
  output state_t                    dbgState
);

  localparam int         BPC    = COUNT_W / 8;
  localparam int         SNAP_W = NUM_CH * COUNT_W;
  localparam int         IDX_W  = $clog2(SNAP_W);
  localparam logic [7:0] ID     = idByte(NUM_CH, COUNT_W);

  logic w_csLevel, w_csRise, w_csFall;
  logic w_sckLevel, w_sckRise, w_sckFall;
  logic w_mosi, w_mosiRise, w_mosiFall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk(clk), .reset(reset), .in(cs),
    .level(w_csLevel), .rise(w_csRise), .fall(w_csFall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
    .clk(clk), .reset(reset), .in(sck),
    .level(w_sckLevel), .rise(w_sckRise), .fall(w_sckFall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
    .clk(clk), .reset(reset), .in(mosi),
    .level(w_mosi), .rise(w_mosiRise), .fall(w_mosiFall)
  );
  assign w_unused = w_sckLevel ^ w_mosiRise ^ w_mosiFall;

  state_t              r_state;
  logic                r_rstQ;
  logic                r_active;
  logic [SNAP_W-1:0]   r_snap;
  logic [7:0]          r_shift;
  logic [6:0]          r_cmd;
  logic [2:0]          r_bitCnt;
  logic [3:0]          r_ch;
  logic [2:0]          r_b;
  logic [3:0]          r_startCh;
  logic                r_valid;
  logic                r_isClear;
  logic [3:0]          r_dataCnt;
  logic [NUM_CH-1:0]   r_clearReq;

  logic [7:0]          w_cmdFull;
  logic                w_cmdValid;
  logic [IDX_W-1:0]    w_base;
  logic [7:0]          w_dataByte;

  // Current pointer is (channel, byte-within-channel); byte 0 is the channel's MSB byte.
  always_comb begin
    w_cmdFull  = {r_cmd, w_mosi};
    w_cmdValid = ((w_cmdFull[7:6] == OP_READ) || (w_cmdFull[7:6] == OP_READ_CLEAR))
                 && (int'(w_cmdFull[5:0]) < NUM_CH);
    w_base     = IDX_W'(int'(r_ch) * COUNT_W + (BPC - 1 - int'(r_b)) * 8);
    w_dataByte = r_valid ? r_snap[w_base +: 8] : INVALID_BYTE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rstQ     <= 1'b1;
      r_active   <= 1'b0;
      r_snap     <= '0;
      r_shift    <= '0;
      r_cmd      <= '0;
      r_bitCnt   <= '0;
      r_ch       <= '0;
      r_b        <= '0;
      r_startCh  <= '0;
      r_valid    <= 1'b0;
      r_isClear  <= 1'b0;
      r_dataCnt  <= '0;
      r_clearReq <= '0;
    end else begin
      r_rstQ     <= 1'b0;
      r_clearReq <= '0;
      // Coming out of reset mid-transaction: sit out the rest of it.
      if (r_rstQ && !w_csLevel) begin
        r_state  <= DRAIN;
        r_active <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_csFall) begin
              r_state   <= CMD;
              r_active  <= 1'b1;
              r_snap    <= encCounts;
              r_shift   <= ID;
              r_cmd     <= '0;
              r_bitCnt  <= '0;
              r_dataCnt <= '0;
              r_valid   <= 1'b0;
              r_isClear <= 1'b0;
            end
          end
          CMD, DATA: begin
            if (w_csRise) begin
              r_state  <= IDLE;
              r_active <= 1'b0;
              r_shift  <= '0;
              if (r_state == DATA && r_valid && r_isClear && int'(r_dataCnt) >= BPC) begin
                for (int i = 0; i < NUM_CH; i++) begin
                  if (i == int'(r_startCh)) r_clearReq[i] <= 1'b1;
                end
              end
            end else begin
              if (w_sckRise) begin
                r_bitCnt <= r_bitCnt + 3'd1;
                if (r_state == CMD) begin
                  r_cmd <= w_cmdFull[6:0];
                  if (r_bitCnt == 3'd7) begin
                    r_state   <= DATA;
                    r_valid   <= w_cmdValid;
                    r_isClear <= (w_cmdFull[7:6] == OP_READ_CLEAR);
                    r_startCh <= w_cmdFull[3:0];
                    r_ch      <= w_cmdValid ? w_cmdFull[3:0] : 4'd0;
                    r_b       <= '0;
                  end
                end else if (r_bitCnt == 3'd7 && int'(r_dataCnt) < BPC) begin
                  r_dataCnt <= r_dataCnt + 4'd1;
                end
              end
              // The fall after the 8th rise of a byte loads the next byte.
              if (w_sckFall) begin
                if (r_state == DATA && r_bitCnt == 3'd0) begin
                  r_shift <= w_dataByte;
                  if (int'(r_b) == BPC - 1) begin
                    r_b  <= '0;
                    r_ch <= (int'(r_ch) == NUM_CH - 1) ? 4'd0 : r_ch + 4'd1;
                  end else begin
                    r_b <= r_b + 3'd1;
                  end
                end else begin
                  r_shift <= {r_shift[6:0], 1'b0};
                end
              end
            end
          end
          DRAIN: begin
            r_active <= 1'b0;
            if (w_csLevel) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign miso     = r_shift[7];
  assign misoEn   = r_active;
  assign busy     = r_active;
  assign clearReq = r_clearReq;
  assign dbgState = r_state;

endmodule

// File: tb/tb_spi_encoder_hub.sv
// Directed plus randomized bench for spi_encoder_hub with a byte-level reference model.
module tb_spi_encoder_hub;
  import spi_enc_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int COUNT_W     = 32;
  localparam int SYNC_STAGES = 2;
  localparam int BPC         = COUNT_W / 8;
  localparam int TOT         = NUM_CH * BPC;
  localparam int HALF        = 8;
  localparam logic [7:0] ID_BYTE = {4'(NUM_CH - 1), 4'(BPC - 1)};

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                      cs, sck, mosi;
  logic                      miso, misoEn, busy;
  logic [NUM_CH-1:0]         clearReq;
  logic [NUM_CH*COUNT_W-1:0] encCounts;
  state_t                    dbgState;

  logic [COUNT_W-1:0] live [NUM_CH];
  logic [COUNT_W-1:0] snap [NUM_CH];

  int total = 0;
  int bad   = 0;
  int clr_cycles = 0;
  int clr_cnt [NUM_CH] = '{default: 0};

  always_comb begin
    encCounts = '0;
    for (int i = 0; i < NUM_CH; i++) encCounts[i*COUNT_W +: COUNT_W] = live[i];
  end

  spi_encoder_hub #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .encCounts(encCounts),
    .cs(cs), .sck(sck), .mosi(mosi),
    .miso(miso), .misoEn(misoEn), .clearReq(clearReq), .busy(busy),
    .dbgState(dbgState)
  );

  // clearReq monitor: counts high cycles overall and per channel
  always @(negedge clk) begin
    if (!reset && clearReq != '0) clr_cycles <= clr_cycles + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!reset && clearReq[i]) clr_cnt[i] <= clr_cnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flat byte index over the frozen bank, MSB byte of each channel first.
  function automatic logic [7:0] model_byte(input int start, input int k);
    int idx, ch, pos;
    idx = (start * BPC + k) % TOT;
    ch  = idx / BPC;
    pos = idx % BPC;
    return 8'(snap[ch] >> (8 * (BPC - 1 - pos)));
  endfunction

  // driver: host shifts nbits MSB-first, sampling miso just before each rise
  task automatic xfer_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      rx  = {rx[6:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic txn(input logic [7:0] cmd, input int ndata, input int change_at,
                     input logic [COUNT_W-1:0] change_val);
    logic [7:0] rx, exp_b;
    logic [NUM_CH-1:0] got_clr, exp_clr;
    int cyc0;
    int cnt0 [NUM_CH];
    bit valid;
    valid = (cmd[7:6] < 2'd2) && (int'(cmd[5:0]) < NUM_CH);
    cyc0  = clr_cycles;
    cnt0  = clr_cnt;
    cs = 1'b0;
    snap = live;
    repeat (8) @(negedge clk);
    xfer_byte(cmd, 8, rx);
    chk("id_byte", rx, ID_BYTE);
    chk("active", {busy, misoEn}, 2'b11);
    for (int k = 0; k < ndata; k++) begin
      if (k == change_at) live[1] = change_val;
      xfer_byte(8'($urandom), 8, rx);
      exp_b = valid ? model_byte(int'(cmd[5:0]), k) : 8'hFF;
      chk($sformatf("data%0d", k), rx, exp_b);
    end
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("idle_out", {busy, misoEn}, 2'b00);
    for (int i = 0; i < NUM_CH; i++) begin
      exp_clr[i] = valid && (cmd[7:6] == 2'b01) && (ndata >= BPC) && (i == int'(cmd[5:0]));
      got_clr[i] = (clr_cnt[i] != cnt0[i]);
    end
    chk("clear_vec", got_clr, exp_clr);
    chk("clear_cycles", clr_cycles - cyc0, (exp_clr != '0) ? 1 : 0);
    for (int i = 0; i < NUM_CH; i++) if (got_clr[i]) live[i] = '0;
  endtask

  initial begin
    logic [7:0] rx;
    int cyc0;
    reset = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    live[0] = 32'h11223344; live[1] = 32'hDEADBEEF;
    live[2] = 32'h00000000; live[3] = 32'h80000001;
    repeat (5) @(negedge clk);
    chk("rst_out", {miso, misoEn, busy, clearReq}, '0);
    chk("rst_state", dbgState, IDLE);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_state", dbgState, IDLE);

    // full read with wrap
    txn(8'h01, 17, -1, '0);
    // snapshot freeze, then the new value becomes visible
    txn(8'h01, 4, 1, 32'h12345678);
    txn(8'h01, 4, -1, '0);
    // read-and-clear: enough bytes, then too few
    txn(8'h42, 4, -1, '0);
    txn(8'h42, 3, -1, '0);
    // invalid commands
    txn(8'h07, 6, -1, '0);
    txn(8'h80, 6, -1, '0);

    // abort in the middle of data byte 2
    cs = 1'b0; snap = live;
    repeat (8) @(negedge clk);
    xfer_byte(8'h00, 8, rx); chk("abort_id", rx, ID_BYTE);
    xfer_byte(8'h00, 8, rx); chk("abort_d0", rx, model_byte(0, 0));
    xfer_byte(8'h00, 8, rx); chk("abort_d1", rx, model_byte(0, 1));
    xfer_byte(8'h00, 3, rx);
    cs = 1'b1;
    repeat (SYNC_STAGES + 2) @(negedge clk);
    chk("abort_busy", busy, 1'b0);
    chk("abort_state", dbgState, IDLE);
    repeat (8) @(negedge clk);
    txn(8'h00, 4, -1, '0);

    // reset in the middle of a read-and-clear transaction
    cyc0 = clr_cycles;
    cs = 1'b0; snap = live;
    repeat (8) @(negedge clk);
    xfer_byte(8'h41, 8, rx); chk("rst_mid_id", rx, ID_BYTE);
    xfer_byte(8'h00, 8, rx); chk("rst_mid_d0", rx, model_byte(1, 0));
    xfer_byte(8'h00, 8, rx); chk("rst_mid_d1", rx, model_byte(1, 1));
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mid_out", {miso, misoEn, busy, clearReq}, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("drain_state", dbgState, DRAIN);
    for (int b = 0; b < 3; b++) xfer_byte(8'($urandom), 8, rx);
    chk("drain_out", {miso, misoEn, busy}, 3'b000);
    cs = 1'b1;
    repeat (8) @(negedge clk);
    chk("drain_exit", dbgState, IDLE);
    chk("drain_no_clear", clr_cycles - cyc0, 0);
    txn(8'h03, 4, -1, '0);

    // randomized transactions
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NUM_CH; i++) live[i] = $urandom;
      txn({2'($urandom_range(0, 3)), 6'($urandom_range(0, 5))}, $urandom_range(0, 10), -1, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
